yourbus_receiver: RTL and testbench
===================================

YOURBUS_RECEIVER -- requirements
Module: yourbus_receiver

Interface
REQ-001 Parameter DATA_W, default 32, width of bus data and of each stored register.
REQ-002 Parameter ADDR_W, default 3, bus address width; register count NREG = 2**ADDR_W (8 by default).
REQ-003 Parameter CNT_W, default 16, width of change counter.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 data_addr  input  ADDR_W  bus target register index; sampled every rising edge.
REQ-007 data  input  DATA_W  bus write value; sampled every rising edge.
REQ-008 rd_addr  input  ADDR_W  readback register index.
REQ-009 rd_data  output  DATA_W  combinational content of register rd_addr.
REQ-010 clr_flags  input  1  single-cycle pulse, clears all update flags.
REQ-011 upd_flags  output  NREG  sticky per-register "value changed" flags.
REQ-012 last_addr  output  ADDR_W  registered copy of last sampled data_addr.
REQ-013 last_data  output  DATA_W  registered copy of last sampled data.
REQ-014 change_cnt  output  CNT_W  count of value-changing writes, saturating.

Function
REQ-015 The bus SHALL have no valid/strobe: every rising edge out of reset writes data into reg[data_addr], 1-cycle latency.
REQ-016 Holding the same address/data across multiple edges SHALL be idempotent (register content unchanged).
REQ-017 A write is "changing" when data differs from reg[data_addr] before the edge.
REQ-018 On a changing write, upd_flags[data_addr] SHALL be set and change_cnt incremented by 1 at that edge.
REQ-019 change_cnt SHALL saturate at 2**CNT_W-1 and never wrap.
REQ-020 clr_flags SHALL clear all upd_flags at the edge; if a changing write occurs the same edge, the written index's flag SHALL end set (set wins); other flags clear.
REQ-021 clr_flags SHALL NOT affect change_cnt or register contents.
REQ-022 rd_data SHALL show the pre-edge value when rd_addr equals the address being written (no write-through bypass).
REQ-023 last_addr/last_data SHALL update every edge with sampled data_addr/data.
REQ-024 All addresses 0..NREG-1 are valid; no out-of-range case exists.

Reset
REQ-025 On rst_n low, immediately and regardless of clk: all registers, upd_flags, last_addr, last_data, change_cnt SHALL be 0.
REQ-026 While rst_n is low no bus write SHALL take effect; the first write occurs at the first rising edge after rst_n deasserts.
REQ-027 Reset asserted mid-sequence SHALL discard all prior state with no partial update.

Configuration
REQ-028 Macro YOURBUS_RECEIVER_SUM_EN: when defined, extra output sum (DATA_W) SHALL equal the modulo-2**DATA_W sum of all NREG registers, registered, valid one cycle after the register update, reset to 0.
REQ-029 When YOURBUS_RECEIVER_SUM_EN is undefined, the sum port and its logic SHALL not exist; all other behaviour identical.

Verification
REQ-030 Reset, then addr 0 data 823359011 (0x31137623) for 1 edge -> rd_addr 0 reads 823359011, upd_flags 0x01, change_cnt 1, last_addr 0.
REQ-031 Continue: addr 1 data 20, then addr 7 data 6078 held 5 edges -> reg1=20, reg7=6078, upd_flags 0x83, change_cnt 3 (no increment while held); with SUM_EN, sum 823365109.
REQ-032 Write addr 1 data 20 again (same value) -> change_cnt stays 3; then clr_flags pulse with addr 2 data 5 same edge -> upd_flags 0x04, change_cnt 4.
REQ-033 rd_addr 7 while writing addr 7 data 1 -> rd_data 6078 before edge, 1 after.
REQ-034 Preload change_cnt to max via alternating values at one address -> stays at 65535.
REQ-035 Assert rst_n low mid-cycle after stimulus -> all outputs 0 without waiting for clk edge.

Source files
------------

// File: rtl/yourbus_receiver.sv
// yourbus_receiver
//   Strobe-less register bus receiver. Every rising edge out of reset writes
//   data into reg[data_addr]. Writes that change a register's value set that
//   register's sticky flag and bump a saturating change counter.
//
//   Optional feature macro: YOURBUS_RECEIVER_SUM_EN adds output 'sum'. This is
//   the registered modulo-2**DATA_W sum of all registers, and it lags the
//   register update by one cycle.
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   data_addr   bus target register index, sampled every edge
//   data        bus write value, sampled every edge
//   rd_addr     readback register index
//   rd_data     combinational content of reg[rd_addr] (no write-through bypass)
//   clr_flags   pulse, clears all update flags (a same-edge set wins)
//   upd_flags   sticky per-register "value changed" flags
//   last_addr   registered copy of the last sampled data_addr
//   last_data   registered copy of the last sampled data
//   change_cnt  saturating count of value-changing writes
//   sum         (YOURBUS_RECEIVER_SUM_EN only) registered sum of all registers
module yourbus_receiver #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    data_addr,
  input  logic [DATA_W-1:0]    data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  input  logic                 clr_flags,
  output logic [2**ADDR_W-1:0] upd_flags,
  output logic [ADDR_W-1:0]    last_addr,
  output logic [DATA_W-1:0]    last_data,
  output logic [CNT_W-1:0]     change_cnt
`ifdef YOURBUS_RECEIVER_SUM_EN
  ,
  output logic [DATA_W-1:0]    sum
`endif
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              changing;
  logic [NREG-1:0]   flags_nxt;

  // A write is "changing" when it alters the stored value. Holding the same
  // address and data over several edges is therefore idempotent.
  always_comb begin
    changing  = (data != regs[data_addr]);
    flags_nxt = clr_flags ? '0 : upd_flags;
    if (changing) begin
      flags_nxt[data_addr] = 1'b1;
    end
  end

  // rd_data reads the stored array directly, so it shows the pre-edge value
  // while the same address is being written.
  assign rd_data = regs[rd_addr];

  // Stage: register array, flags, counter and last-sample copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      upd_flags  <= '0;
      last_addr  <= '0;
      last_data  <= '0;
      change_cnt <= '0;
    end else begin
      regs[data_addr] <= data;
      upd_flags       <= flags_nxt;
      last_addr       <= data_addr;
      last_data       <= data;
      if (changing && (change_cnt != {CNT_W{1'b1}})) begin
        change_cnt <= change_cnt + 1'b1;
      end
    end
  end

`ifdef YOURBUS_RECEIVER_SUM_EN
  logic [DATA_W-1:0] sum_all;

  always_comb begin
    sum_all = '0;
    for (int i = 0; i < NREG; i++) begin
      sum_all = sum_all + regs[i];
    end
  end

  // Stage: sum of the already-updated registers, one cycle behind them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else begin
      sum <= sum_all;
    end
  end
`endif

endmodule

// File: tb/tb_yourbus_receiver.sv
module tb_yourbus_receiver;

  logic        clk;
  logic        rst_n;
  logic [2:0]  data_addr;
  logic [31:0] data;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        clr_flags;
  logic [7:0]  upd_flags;
  logic [2:0]  last_addr;
  logic [31:0] last_data;
  logic [15:0] change_cnt;
`ifdef YOURBUS_RECEIVER_SUM_EN
  logic [31:0] sum;
`endif

  yourbus_receiver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_addr  (data_addr),
    .data       (data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .clr_flags  (clr_flags),
    .upd_flags  (upd_flags),
    .last_addr  (last_addr),
    .last_data  (last_data),
    .change_cnt (change_cnt)
`ifdef YOURBUS_RECEIVER_SUM_EN
    ,
    .sum        (sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain arrays and integers following the rules directly.
  logic [31:0] m_regs [8];
  logic [7:0]  m_flags;
  int          m_cnt;
  logic [2:0]  m_last_addr;
  logic [31:0] m_last_data;
  logic [31:0] m_sum;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    logic        clr;
    logic [2:0]  rd;
    logic [31:0] exp_rd;
    logic [7:0]  exp_flags;
    int          exp_cnt;
  } vec_t;

  vec_t vt [9];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_flags = '0; m_cnt = 0; m_last_addr = '0; m_last_data = '0; m_sum = '0;
  endtask

  task automatic check_model();
    cmp("rd_data",    {32'd0, rd_data},    {32'd0, m_regs[rd_addr]});
    cmp("upd_flags",  {56'd0, upd_flags},  {56'd0, m_flags});
    cmp("change_cnt", {48'd0, change_cnt}, 64'(m_cnt));
    cmp("last_addr",  {61'd0, last_addr},  {61'd0, m_last_addr});
    cmp("last_data",  {32'd0, last_data},  {32'd0, m_last_data});
`ifdef YOURBUS_RECEIVER_SUM_EN
    cmp("sum",        {32'd0, sum},        {32'd0, m_sum});
`endif
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_flags"}, {56'd0, upd_flags},  64'd0);
    cmp({tag, "_cnt"},   {48'd0, change_cnt}, 64'd0);
    cmp({tag, "_laddr"}, {61'd0, last_addr},  64'd0);
    cmp({tag, "_ldata"}, {32'd0, last_data},  64'd0);
`ifdef YOURBUS_RECEIVER_SUM_EN
    cmp({tag, "_sum"},   {32'd0, sum},        64'd0);
`endif
  endtask

  // Drive at the falling edge, let one rising edge pass, update the model,
  // then sample 1 time unit later.
  task automatic apply(input logic [2:0] a, input logic [31:0] d, input logic c,
                       input logic [2:0] r, input bit chk);
    logic [31:0] s;
    @(negedge clk);
    data_addr = a; data = d; clr_flags = c; rd_addr = r;
    @(posedge clk);
    s = '0;
    for (int i = 0; i < 8; i++) s = s + m_regs[i];
    if (rst_n) begin
      m_sum = s;
      if (c) m_flags = '0;
      if (d != m_regs[a]) begin
        m_flags[a] = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end
      m_regs[a]   = d;
      m_last_addr = a;
      m_last_data = d;
    end
    #1;
    if (chk) check_model();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pool [4];
    vt[0] = '{3'd0, 32'h31137623, 1'b0, 3'd0, 32'h31137623, 8'h01, 1};
    vt[1] = '{3'd1, 32'd20,       1'b0, 3'd1, 32'd20,       8'h03, 2};
    vt[2] = '{3'd7, 32'd6078,     1'b0, 3'd7, 32'd6078,     8'h83, 3};
    vt[3] = '{3'd7, 32'd6078,     1'b0, 3'd7, 32'd6078,     8'h83, 3};
    vt[4] = '{3'd7, 32'd6078,     1'b0, 3'd0, 32'h31137623, 8'h83, 3};
    vt[5] = '{3'd7, 32'd6078,     1'b0, 3'd1, 32'd20,       8'h83, 3};
    vt[6] = '{3'd7, 32'd6078,     1'b0, 3'd7, 32'd6078,     8'h83, 3};
    vt[7] = '{3'd1, 32'd20,       1'b0, 3'd1, 32'd20,       8'h83, 3};
    vt[8] = '{3'd2, 32'd5,        1'b1, 3'd2, 32'd5,        8'h04, 4};

    rst_n = 1'b0; data_addr = '0; data = '0; clr_flags = 1'b0; rd_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    cmp("reset_rd0", {32'd0, rd_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors from the reset state.
    for (int i = 0; i < 9; i++) begin
      apply(vt[i].addr, vt[i].data, vt[i].clr, vt[i].rd, 1'b1);
      cmp($sformatf("vec%0d_rd", i),    {32'd0, rd_data},    {32'd0, vt[i].exp_rd});
      cmp($sformatf("vec%0d_flags", i), {56'd0, upd_flags},  {56'd0, vt[i].exp_flags});
      cmp($sformatf("vec%0d_cnt", i),   {48'd0, change_cnt}, 64'(vt[i].exp_cnt));
      cmp($sformatf("vec%0d_laddr", i), {61'd0, last_addr},  {61'd0, vt[i].addr});
`ifdef YOURBUS_RECEIVER_SUM_EN
      if (i == 7) cmp("vec_sum", {32'd0, sum}, 64'd823365109);
`endif
    end

    // No write-through: rd_data shows the old value until the edge.
    @(negedge clk);
    data_addr = 3'd7; data = 32'd1; rd_addr = 3'd7; clr_flags = 1'b0;
    #1;
    cmp("bypass_before", {32'd0, rd_data}, 64'd6078);
    apply(3'd7, 32'd1, 1'b0, 3'd7, 1'b1);
    cmp("bypass_after", {32'd0, rd_data}, 64'd1);

    // Randomized traffic against the model; a small data pool makes repeats
    // (non-changing writes) common.
    pool[0] = 32'd0; pool[1] = 32'hdeadbeef; pool[2] = 32'd7; pool[3] = 32'hffffffff;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 3)];
      apply(3'($urandom_range(0, 7)), d, ($urandom_range(0, 7) == 0),
            3'($urandom_range(0, 7)), 1'b1);
    end

    // Drive the counter into saturation by alternating values at one address.
    for (int i = 0; i < 65540; i++) begin
      apply(3'd4, i[0] ? 32'h55 : 32'haa, 1'b0, 3'd4, (i % 4096) == 0);
    end
    check_model();
    cmp("sat_cnt", {48'd0, change_cnt}, 64'd65535);
    apply(3'd4, 32'h1234, 1'b0, 3'd4, 1'b1);
    cmp("sat_hold", {48'd0, change_cnt}, 64'd65535);

    // Mid-cycle asynchronous reset: outputs clear without a clock edge.
    apply(3'd5, 32'h77, 1'b0, 3'd5, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async");
    model_reset();
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #0.1;
      cmp($sformatf("async_reg%0d", i), {32'd0, rd_data}, 64'd0);
    end

    // Writes are blocked while reset is held; the first one lands on the first
    // edge after release.
    data_addr = 3'd3; data = 32'd99; rd_addr = 3'd3;
    repeat (2) @(posedge clk);
    #1;
    cmp("held_rd", {32'd0, rd_data}, 64'd0);
    check_all_zero("held");
    @(negedge clk);
    rst_n = 1'b1;
    apply(3'd3, 32'd99, 1'b0, 3'd3, 1'b1);
    cmp("first_write", {32'd0, rd_data}, 64'd99);
    cmp("first_cnt", {48'd0, change_cnt}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
